// File: rtl/scan_chain_loader_pkg.sv
// Shared definitions for the configuration scan-chain loader.
// Contents: FSM state encoding and width helpers for the bit and word counters.
// Optional readback feature: SCAN_READBACK_EN (no definitions depend on it here).
package scan_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_WORD = 2'd1;
  localparam state_t SHIFT     = 2'd2;
  localparam state_t DONE      = 2'd3;

  // Words per full load: ceil(chain_len / word_w)
  function automatic int unsigned num_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bit-remaining counter must hold chain_len itself
  function automatic int unsigned bit_cnt_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Word counter must hold num_words itself
  function automatic int unsigned word_cnt_w(input int unsigned chain_len,
                                             input int unsigned word_w);
    return $clog2(num_words(chain_len, word_w) + 1);
  endfunction

endpackage

// File: rtl/scan_chain_loader_if.sv
// Bus bundle between the configuration source and the scan-chain loader.
// Signals: start/abort pulses, cfg_data/cfg_valid/cfg_ready word handshake,
// scan_en/scan_in chain drive, busy/done status.
// With SCAN_READBACK_EN: scan_ret (chain tail), rd_data/rd_valid readback.
// master = configuration source side, slave = loader side.
interface scan_chain_loader_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [WORD_WIDTH-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  scan_en;
  logic                  scan_in;
  logic                  busy;
  logic                  done;
`ifdef SCAN_READBACK_EN
  logic                  scan_ret;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output start, abort, cfg_data, cfg_valid, scan_ret,
    input  cfg_ready, scan_en, scan_in, busy, done, rd_data, rd_valid
  );
  modport slave (
    input  start, abort, cfg_data, cfg_valid, scan_ret,
    output cfg_ready, scan_en, scan_in, busy, done, rd_data, rd_valid
  );
`else
  modport master (
    output start, abort, cfg_data, cfg_valid,
    input  cfg_ready, scan_en, scan_in, busy, done
  );
  modport slave (
    input  start, abort, cfg_data, cfg_valid,
    output cfg_ready, scan_en, scan_in, busy, done
  );
`endif
endinterface

// File: rtl/scan_chain_loader_piso.sv
// scan_piso: parallel-load shift register, shifts right (LSB out) with the
// serial input entering at the MSB. Load has priority over shift.
// Ports: clk, reset (async high), load_i/data_i parallel load,
// shift_i/sin_i serial shift, q_o register contents.
module scan_piso #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sr_q, sr_d;

  // Next register value
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = (sr_q >> 1) | (WIDTH'(sin_i) << (WIDTH - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;
endmodule

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: serializes configuration words LSB-first onto the head of
// the configuration scan chain so that after a full load chain bit j holds
// word[j/WORD_WIDTH][j%WORD_WIDTH].
// Ports: clk, reset (async, active high), bus (slave modport of
// scan_chain_loader_if): start/abort, cfg_* handshake, scan_en/scan_in,
// busy/done. Optional macro SCAN_READBACK_EN adds scan_ret capture and
// rd_data/rd_valid readback of the previous chain contents.
module scan_chain_loader
  import scan_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 64,
  parameter int unsigned WORD_WIDTH   = 16
) (
  input logic                clk,
  input logic                reset,
  scan_chain_loader_if.slave bus
);
  localparam int unsigned NUM_WORDS = num_words(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned BCW       = bit_cnt_w(CHAIN_LENGTH);
  localparam int unsigned WCW       = word_cnt_w(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned SCW       = $clog2(WORD_WIDTH + 1);

  state_t           state_q, state_d;
  logic [BCW-1:0]   bits_rem_q, bits_rem_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [SCW-1:0]   shift_cnt_q, shift_cnt_d;
  logic             scan_en_q, scan_en_d;
  logic             scan_in_q, scan_in_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_load, tx_shift;
  logic [SCW-1:0]   n_c;
  logic [WORD_WIDTH-1:0] tx_q;
  logic             unused_tx_hi;

  // Bits in the next word: a partial final word carries only what remains
  assign n_c = (32'(bits_rem_q) < WORD_WIDTH) ? SCW'(bits_rem_q) : SCW'(WORD_WIDTH);

  // Bit 0 goes straight to scan_in_q on acceptance, so the register holds
  // the word pre-shifted and its LSB is always the next bit to send.
  scan_piso #(.WIDTH(WORD_WIDTH)) u_tx_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tx_load),
    .data_i  (bus.cfg_data >> 1),
    .shift_i (tx_shift),
    .sin_i   (1'b0),
    .q_o     (tx_q)
  );
  assign unused_tx_hi = ^tx_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    bits_rem_d  = bits_rem_q;
    word_cnt_d  = word_cnt_q;
    shift_cnt_d = shift_cnt_q;
    scan_en_d   = 1'b0;
    scan_in_d   = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = WAIT_WORD;
          word_cnt_d = '0;
          bits_rem_d = BCW'(CHAIN_LENGTH);
        end
      end
      WAIT_WORD: begin
        if (bus.cfg_valid && cfg_ready_q) begin
          tx_load     = 1'b1;
          shift_cnt_d = n_c;
          bits_rem_d  = bits_rem_q - BCW'(n_c);
          word_cnt_d  = word_cnt_q + WCW'(1);
          scan_en_d   = 1'b1;
          scan_in_d   = bus.cfg_data[0];
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_cnt_q == SCW'(1)) begin
          state_d = (word_cnt_q == WCW'(NUM_WORDS)) ? DONE : WAIT_WORD;
        end else begin
          shift_cnt_d = shift_cnt_q - SCW'(1);
          scan_en_d   = 1'b1;
          scan_in_d   = tx_q[0];
          tx_shift    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start or handshake
    if (bus.abort) begin
      state_d   = IDLE;
      scan_en_d = 1'b0;
      scan_in_d = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
    end

    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == WAIT_WORD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bits_rem_q  <= '0;
      word_cnt_q  <= '0;
      shift_cnt_q <= '0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_rem_q  <= bits_rem_d;
      word_cnt_q  <= word_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.scan_en   = scan_en_q;
  assign bus.scan_in   = scan_in_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SCAN_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_q, rb_next_c, rd_data_q, rd_data_d;
  logic [SCW-1:0]        word_n_q, word_n_d;
  logic                  rd_valid_q, rd_valid_d;

  // Tail bits enter MSB-side on every shifting edge; abort clears the capture
  scan_piso #(.WIDTH(WORD_WIDTH)) u_rx_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (bus.abort),
    .data_i  ('0),
    .shift_i (scan_en_q),
    .sin_i   (bus.scan_ret),
    .q_o     (rb_q)
  );

  // Capture value including the bit arriving on this edge
  assign rb_next_c = (rb_q >> 1) | (WORD_WIDTH'(bus.scan_ret) << (WORD_WIDTH - 1));

  // On the last bit of a word, right-justify the n captured bits
  always_comb begin
    word_n_d   = tx_load ? n_c : word_n_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (bus.abort) begin
      rd_data_d = '0;
    end else if (state_q == SHIFT && shift_cnt_q == SCW'(1)) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rb_next_c >> (SCW'(WORD_WIDTH) - word_n_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_n_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      word_n_q   <= word_n_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader with a 10-flop chain and 4-bit words.
// Honors SCAN_READBACK_EN when defined (readback sequence checks).
module tb_scan_chain_loader;
  localparam int unsigned CL = 10;
  localparam int unsigned WW = 4;
  localparam int unsigned NW = 3;

  typedef logic [NW-1:0][WW-1:0] words_t;

  typedef struct {
    words_t         w;
    int             stall;
    logic [CL-1:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_chain_loader_if #(.WORD_WIDTH(WW)) bus ();

  scan_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Attached chain: head at bit CL-1, tail (scan_out) at bit 0
  logic [CL-1:0] chain;
  logic          preload;
  logic [CL-1:0] preload_val;
  always @(posedge clk) begin
    if (preload) chain <= preload_val;
    else if (bus.scan_en) chain <= {bus.scan_in, chain[CL-1:1]};
  end

`ifdef SCAN_READBACK_EN
  assign bus.scan_ret = chain[0];
`endif

  // Running totals; tasks take differences
  int en_total = 0;
  int done_total = 0;
  logic [WW-1:0] rd_q[$];
  always @(negedge clk) begin
    if (bus.scan_en === 1'b1) en_total++;
    if (bus.done === 1'b1) done_total++;
`ifdef SCAN_READBACK_EN
    if (bus.rd_valid === 1'b1) rd_q.push_back(bus.rd_data);
`endif
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference image: chain bit j = word[j/WW][j%WW]
  function automatic logic [CL-1:0] model_image(input words_t w);
    logic [CL-1:0] r;
    for (int j = 0; j < CL; j++) r[j] = w[j / WW][j % WW];
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cfg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic send_word(input logic [WW-1:0] d);
    bus.cfg_data  = d;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_preload(input logic [CL-1:0] v);
    preload_val = v;
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  // Full load with optional stall cycles before each word
  task automatic run_load(input words_t w, input int stall, output int en_used, output int dn);
    int en0, dn0, rq0;
    bit ok;
    bit stall_bad;
    logic [CL-1:0] old;
    en0 = en_total;
    dn0 = done_total;
    rq0 = rd_q.size();
    old = chain;
    stall_bad = 1'b0;
    en_used = 0;
    dn = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      wait_ready(ok);
      if (!ok) begin
        check("cfg_ready_timeout", 0, 1);
        return;
      end
      for (int s = 0; s < stall; s++) begin
        if (bus.scan_en !== 1'b0) stall_bad = 1'b1;
        tick();
      end
      send_word(w[i]);
      if (i == 0) begin
        check("first_bit_scan_en", bus.scan_en, 1);
        check("first_bit_scan_in", bus.scan_in, w[0][0]);
      end
    end
    if (stall > 0) check("stall_scan_en_low", stall_bad, 0);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("done_seen", ok, 1);
    if (ok) begin
      check("busy_during_done", bus.busy, 1);
      tick();
      check("done_one_cycle", bus.done, 0);
      check("busy_after_done", bus.busy, 0);
    end
    tick();
    en_used = en_total - en0;
    dn = done_total - dn0;
`ifdef SCAN_READBACK_EN
    check("rd_count", rd_q.size() - rq0, NW);
    if (rd_q.size() - rq0 == NW) begin
      for (int i = 0; i < NW; i++) begin
        int n;
        logic [CL-1:0] sh;
        logic [WW-1:0] expw;
        n = (CL - i * WW < WW) ? CL - i * WW : WW;
        sh = old >> (i * WW);
        expw = '0;
        for (int b = 0; b < n; b++) expw[b] = sh[b];
        check("rd_data", rd_q[rq0 + i], expw);
      end
    end
`endif
  endtask

  vec_t vt[6];

  initial begin
    int en_used, dn, en0, dn0;
    bit ok;
    words_t rw;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_data = '0;
    bus.cfg_valid = 1'b0;
    preload = 1'b0;
    preload_val = '0;

    vt[0] = '{w: 12'h35A, stall: 0, exp: 10'h35A};
    vt[1] = '{w: 12'h35A, stall: 5, exp: 10'h35A};
    vt[2] = '{w: 12'hFFF, stall: 1, exp: 10'h3FF};
    vt[3] = '{w: 12'h000, stall: 2, exp: 10'h000};
    vt[4] = '{w: 12'hFA5, stall: 0, exp: 10'h3A5};
    vt[5] = '{w: 12'h321, stall: 3, exp: 10'h321};

    tick();
    tick();
    check("rst_scan_en", bus.scan_en, 0);
    check("rst_scan_in", bus.scan_in, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
`ifdef SCAN_READBACK_EN
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
`endif
    reset = 1'b0;
    tick();
    check("idle_cfg_ready", bus.cfg_ready, 0);
    check("idle_busy", bus.busy, 0);

    // Table-driven full loads; first one starts from a known chain image
    do_preload(10'h2C7);
    for (int v = 0; v < 6; v++) begin
`ifdef SCAN_READBACK_EN
      int rq0;
      rq0 = rd_q.size();
`endif
      run_load(vt[v].w, vt[v].stall, en_used, dn);
      check("vec_chain", chain, vt[v].exp);
      check("vec_scan_en_cycles", en_used, CL);
      check("vec_done_count", dn, 1);
`ifdef SCAN_READBACK_EN
      if (v == 0 && rd_q.size() - rq0 == NW) begin
        check("rb_word0", rd_q[rq0], 4'h7);
        check("rb_word1", rd_q[rq0 + 1], 4'hC);
        check("rb_word2", rd_q[rq0 + 2], 4'h2);
      end
`endif
    end

    // Randomized loads against the reference image
    for (int r = 0; r < 15; r++) begin
      rw = words_t'($urandom);
      run_load(rw, int'($urandom_range(0, 3)), en_used, dn);
      check("rand_chain", chain, model_image(rw));
      check("rand_scan_en_cycles", en_used, CL);
      check("rand_done_count", dn, 1);
    end

    // Abort on the 3rd shift cycle of word 1, then a clean reload
    en0 = en_total;
    dn0 = done_total;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_ready(ok);
    check("abort_ready0", ok, 1);
    send_word(4'hA);
    wait_ready(ok);
    check("abort_ready1", ok, 1);
    send_word(4'h5);
    tick();
    tick();
    check("abort_shift3_en", bus.scan_en, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_scan_en", bus.scan_en, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_cfg_ready", bus.cfg_ready, 0);
    tick();
    tick();
    tick();
    check("abort_en_cycles", en_total - en0, 7);
    check("abort_no_done", done_total - dn0, 0);
    run_load(12'h35A, 0, en_used, dn);
    check("reload_chain", chain, 10'h35A);
    check("reload_done", dn, 1);

    // Start while busy ignored; handshake with abort drops the word
    en0 = en_total;
    dn0 = done_total;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_ready(ok);
    send_word(4'hF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start_ignored", bus.busy, 1);
    check("busy_start_shift", bus.scan_en, 1);
    wait_ready(ok);
    check("drop_ready", ok, 1);
    bus.cfg_data = 4'h3;
    bus.cfg_valid = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.abort = 1'b0;
    check("drop_busy", bus.busy, 0);
    check("drop_cfg_ready", bus.cfg_ready, 0);
    check("drop_scan_en", bus.scan_en, 0);
    tick();
    tick();
    tick();
    check("drop_en_cycles", en_total - en0, 4);
    check("drop_no_done", done_total - dn0, 0);

    // Abort and start together while idle: stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    check("abort_start_ready", bus.cfg_ready, 0);

    // Async reset between clock edges during SHIFT
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_ready(ok);
    send_word(4'hF);
    check("pre_reset_scan_in", bus.scan_in, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_scan_en", bus.scan_en, 0);
    check("async_scan_in", bus.scan_in, 0);
    check("async_busy", bus.busy, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_ready", bus.cfg_ready, 0);
    check("post_reset_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Transmit end of the configuration scan chain.
- Accepts parallel configuration words over a valid/ready handshake and serializes them onto the chain's scan_in. Drives scan_en so that after one complete load, every chain flop holds its intended bit.
- Sits between the top-level configuration interface and the head of the PE/buffer scan chain.

Parameters:
- CHAIN_LENGTH, 64, total number of scan flops in the driven chain (>=1).
- WORD_WIDTH, 16, width of each input configuration word (>=1).
- NUM_WORDS, derived as ceil(CHAIN_LENGTH/WORD_WIDTH), number of words per full load (localparam).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a full chain load
- abort  in  1  pulse; cancels a load in progress
- cfg_data  in  WORD_WIDTH  configuration word
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader can accept a word
- scan_en  out  1  chain shift enable, registered
- scan_in  out  1  serial bit into chain head, registered
- busy  out  1  load in progress (state != IDLE)
- done  out  1  one-cycle pulse when a full load completes

Behaviour:
- Reset (async, immediate): state=IDLE; scan_en=0, scan_in=0, cfg_ready=0, busy=0, done=0; all counters 0.
- Bit ordering: each word is shifted LSB-first, and words go in arrival order. The chain shifts from the head toward the tail, so the first bit sent ends at chain bit 0. After a load, chain bit j = word[j/WORD_WIDTH][j%WORD_WIDTH].
- FSM states: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - cfg_ready=0.
  - start=1 -> WAIT_WORD; word counter=0, bit-remaining=CHAIN_LENGTH.
- WAIT_WORD:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, the word is latched into the shift register and the state goes to SHIFT.
  - n = min(WORD_WIDTH, bits remaining).
- SHIFT:
  - cfg_ready=0.
  - For exactly n consecutive cycles, scan_en=1 and scan_in=current LSB; the register shifts right one bit per cycle.
  - After the n-th bit: if bits remain -> WAIT_WORD, otherwise -> DONE.
  - Unused high bits of a partial final word are discarded.
- DONE: done=1 for one cycle -> IDLE.
- Latency: a word accepted at edge k drives scan_en=1/scan_in=bit0 during cycle k+1. The chain captures bit i at edge k+1+i. Back-to-back words therefore leave a one-cycle scan_en=0 gap (the WAIT_WORD cycle).
- scan_en is low in every state except SHIFT, so the chain holds its value while idle and during gaps.
- start while busy is ignored.
- abort in any non-IDLE state -> IDLE next edge; scan_en=0 and done is not asserted. Chain contents are then partial and undefined.
- abort and start in the same cycle while IDLE: abort wins and the state stays IDLE.
- abort and the cfg handshake in the same cycle: abort wins and the word is dropped.
- A cfg_valid held high while not ready has no effect.
- CHAIN_LENGTH an exact multiple of WORD_WIDTH: no partial word. The final word's bit count equals WORD_WIDTH.

Optional Feature:
- Macro: SCAN_READBACK_EN.
- When defined, the following ports are added:
  - scan_ret (in, 1): tail scan_out of the chain.
  - rd_data (out, WORD_WIDTH).
  - rd_valid (out, 1).
- Readback capture:
  - On every edge where scan_en=1, scan_ret is shifted into a readback register MSB-side, so the LSB arrives first.
  - After each word's n bits, rd_data presents the previous chain contents for that word slot: right-justified, with unused high bits 0.
  - rd_valid pulses one cycle in the cycle after the last bit. There is no backpressure.
  - Readback resets to 0; abort clears it and suppresses rd_valid.
- When undefined: these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package scan_loader_pkg:
  - state enum (IDLE, WAIT_WORD, SHIFT, DONE).
  - Width helper constants: bit-counter width $clog2(CHAIN_LENGTH+1), word-counter width $clog2(NUM_WORDS+1).
- One sub-module: scan_piso — a WORD_WIDTH parallel-load, LSB-out shift register with load/shift enables. It is instanced for transmit and, under SCAN_READBACK_EN, mirrored for capture.

Test Plan:
- Full load, CHAIN_LENGTH=10, WORD_WIDTH=4, words 0xA,0x5,0x3 with an attached 10-bit chain model -> chain q=10'h35A. Exactly 10 scan_en-high cycles, done pulses once, busy falls the cycle after done.
- cfg_valid stalled 5 cycles between words -> scan_en stays 0 during the stall and the final chain content is unchanged (10'h35A).
- abort asserted during the 3rd shift cycle of word 1 -> next cycle scan_en=0, state IDLE, no done. A subsequent start plus a full load yields the correct image.
- start pulsed while busy, and a cfg handshake with abort in the same cycle -> start ignored, word dropped, no extra scan_en cycles.
- Async reset asserted mid-SHIFT between clock edges -> scan_en, scan_in and busy go 0 immediately without a clock; cfg_ready=0 after release.
- SCAN_READBACK_EN: chain preloaded to 10'h2C7, load 0xA,0x5,0x3 -> rd_data sequence 0x7, 0xC, 0x2 with one rd_valid pulse per word; chain ends at 10'h35A.
